// File: rtl/sync_fifo_sp_ctrl.sv
// FIFO controller over a single-port RAM with a 2-entry show-ahead output buffer; 3-cycle write-to-out latency.
// Backpressure: in_ready drops when the RAM is full or a RAM read wins arbitration; out_ready only drains the buffer.
module sync_fifo_sp_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 2) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             ram_cs,
   output logic             ram_wr,
   output logic [AW-1:0]    ram_addr,
   output logic [WIDTH-1:0] ram_wdata,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic [CW-1:0]    fill_cnt
);

   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, addr_q;
   logic [AW:0]      ram_cnt_q, ram_cnt_d;
   logic             rd_inflight_q, rd_inflight_d;
   logic             prio_rd_q, prio_rd_d;
   logic [1:0]       obuf_cnt_q, obuf_cnt_d;
   logic [WIDTH-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
   logic [CW-1:0]    fill_q, fill_d;
   logic             not_full, want_wr, want_rd, rd_grant, wr_grant, pop, cap;

   // Requests look only at registered state, so in_ready never depends on out_ready.
   always_comb begin
      not_full = ram_cnt_q < DEPTH_C;
      want_wr  = rst_n && in_valid && not_full;
      want_rd  = (ram_cnt_q != '0) && ((obuf_cnt_q + {1'b0, rd_inflight_q}) < 2'd2);
      rd_grant = want_rd && (!want_wr || prio_rd_q);
      wr_grant = want_wr && !rd_grant;
      pop      = (obuf_cnt_q != 2'd0) && out_ready;
      cap      = rd_inflight_q;
   end

   assign in_ready  = rst_n && not_full && !rd_grant;
   assign ram_cs    = wr_grant || rd_grant;
   assign ram_wr    = wr_grant;
   assign ram_addr  = wr_grant ? wr_ptr_q : (rd_grant ? rd_ptr_q : addr_q);
   assign ram_wdata = in_data;
   assign out_valid = obuf_cnt_q != 2'd0;
   assign out_data  = obuf0_q;
   assign fill_cnt  = fill_q;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ram_cnt_d     = ram_cnt_q;
      rd_inflight_d = rd_grant;
      prio_rd_d     = prio_rd_q;
      obuf_cnt_d    = obuf_cnt_q;
      obuf0_d       = obuf0_q;
      obuf1_d       = obuf1_q;
      fill_d        = fill_q;

      if (wr_grant) begin
         wr_ptr_d  = wr_ptr_q + AW'(1);
         ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
      end else if (rd_grant) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
      end

      if (want_wr && want_rd) prio_rd_d = !rd_grant;

      // Buffer is a 2-deep shift register; head always sits in obuf0.
      if (pop && cap) begin
         if (obuf_cnt_q == 2'd1) begin
            obuf0_d = ram_rdata;
         end else begin
            obuf0_d = obuf1_q;
            obuf1_d = ram_rdata;
         end
      end else if (pop) begin
         obuf0_d    = obuf1_q;
         obuf_cnt_d = obuf_cnt_q - 2'd1;
      end else if (cap) begin
         if (obuf_cnt_q == 2'd0) obuf0_d = ram_rdata;
         else                    obuf1_d = ram_rdata;
         obuf_cnt_d = obuf_cnt_q + 2'd1;
      end

      if (wr_grant && !pop)      fill_d = fill_q + CW'(1);
      else if (pop && !wr_grant) fill_d = fill_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         addr_q        <= '0;
         ram_cnt_q     <= '0;
         rd_inflight_q <= 1'b0;
         prio_rd_q     <= 1'b0;
         obuf_cnt_q    <= 2'd0;
         obuf0_q       <= '0;
         obuf1_q       <= '0;
         fill_q        <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         addr_q        <= ram_addr;
         ram_cnt_q     <= ram_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         prio_rd_q     <= prio_rd_d;
         obuf_cnt_q    <= obuf_cnt_d;
         obuf0_q       <= obuf0_d;
         obuf1_q       <= obuf1_d;
         fill_q        <= fill_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_sp_ctrl.sv
// Scoreboard bench for sync_fifo_sp_ctrl with an attached single-port RAM model.
module tb_sync_fifo_sp_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 2) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, out_data, ram_wdata, ram_rdata;
   logic             ram_cs, ram_wr;
   logic [AW-1:0]    ram_addr;
   logic [CW-1:0]    fill_cnt;

   int checks   = 0;
   int failures = 0;
   bit stream_phase = 1'b0;
   int lowrun = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] mem[DEPTH];

   sync_fifo_sp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fill_cnt(fill_cnt)
   );

   always #5 clk = ~clk;

   // Single-port RAM, registered read.
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_wr) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Monitor: reference occupancy is the queue length; pops compare against queue head.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         lowrun = 0;
      end else begin
         check("fill_cnt_vs_model", 32'(fill_cnt), 32'(exp_q.size()));
         check("fill_cnt_max", 32'(fill_cnt > CW'(DEPTH + 2)), 32'd0);
         if (ram_cs && !ram_wr) check("accept_during_read", 32'(in_valid && in_ready), 32'd0);
         if (stream_phase && in_valid) begin
            if (!in_ready) begin
               lowrun++;
               check("in_ready_low_run", 32'(lowrun > 1), 32'd0);
            end else begin
               lowrun = 0;
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL pop_underflow actual=0x%0h required=empty", out_data);
            end else begin
               logic [WIDTH-1:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL out_data actual=0x%0h required=0x%0h", out_data, e);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   task automatic push(input logic [WIDTH-1:0] d);
      int guard;
      guard = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("push_timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!out_valid && fill_cnt == '0) break;
         guard++;
         if (guard > 100) break;
      end
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_fill_cnt", 32'(fill_cnt), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, guard;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_ram_cs", 32'(ram_cs), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_fill_cnt", 32'(fill_cnt), 32'd0);

      // First-word latency
      @(posedge clk); #1;
      rst_n = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      check("c0_in_ready", 32'(in_ready), 32'd1);
      check("c0_ram_cs", 32'(ram_cs), 32'd1);
      check("c0_ram_wr", 32'(ram_wr), 32'd1);
      check("c0_ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("c1_ram_cs", 32'(ram_cs), 32'd1);
      check("c1_ram_wr", 32'(ram_wr), 32'd0);
      check("c1_ram_addr", 32'(ram_addr), 32'd0);
      @(negedge clk);
      check("c2_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("c3_out_valid", 32'(out_valid), 32'd1);
      check("c3_out_data", 32'(out_data), 32'hA5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Arbitration: both pointers at 1, prio_rd still 0
      in_valid = 1'b1; in_data = 8'h11;
      @(negedge clk);
      check("arb_a_wr", 32'(ram_cs && ram_wr), 32'd1);
      check("arb_a_addr", 32'(ram_addr), 32'd1);
      @(posedge clk); #1;
      in_data = 8'h22;
      @(negedge clk);
      check("arb_b_in_ready", 32'(in_ready), 32'd1);
      check("arb_b_wr", 32'(ram_cs && ram_wr), 32'd1);
      check("arb_b_addr", 32'(ram_addr), 32'd2);
      @(posedge clk); #1;
      in_data = 8'h33;
      @(negedge clk);
      check("arb_c_in_ready", 32'(in_ready), 32'd0);
      check("arb_c_rd", 32'(ram_cs && !ram_wr), 32'd1);
      check("arb_c_addr", 32'(ram_addr), 32'd1);
      @(negedge clk);
      check("arb_d_in_ready", 32'(in_ready), 32'd1);
      check("arb_d_wr", 32'(ram_cs && ram_wr), 32'd1);
      check("arb_d_addr", 32'(ram_addr), 32'd3);
      drain();

      // Fill to DEPTH+2, then full
      for (int i = 1; i <= 10; i++) push(8'(i));
      @(posedge clk); #1;
      in_data = 8'hEE;
      repeat (4) begin
         @(negedge clk);
         check("full_in_ready", 32'(in_ready), 32'd0);
         check("full_fill_cnt", 32'(fill_cnt), 32'd10);
      end
      drain();

      // Continuous streaming across pointer wrap
      out_ready = 1'b1;
      stream_phase = 1'b1;
      for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
      stream_phase = 1'b0;
      drain();

      // Random traffic
      acc = 0; guard = 0;
      while (acc < 200 && guard < 5000) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         guard++;
      end
      check("random_accepted", 32'(acc), 32'd200);
      drain();

      // Reset with a read in flight and five entries held
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_fill", 32'(fill_cnt), 32'd6);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_read", 32'(ram_cs && !ram_wr), 32'd1);
      @(posedge clk); #1;
      check("pre_rst_fill5", 32'(fill_cnt), 32'd5);
      in_valid = 1'b1; in_data = 8'h3C;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_ram_cs", 32'(ram_cs), 32'd0);
      check("mid_rst_fill", 32'(fill_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("post_rst_out_valid", 32'(out_valid), 32'd1);
      check("post_rst_first", 32'(out_data), 32'h3C);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_sp_ctrl.md
Name: sync_fifo_sp_ctrl

Overview:
- Synchronous FIFO controller that drives one single-port RAM (one access per cycle, 1-cycle registered read) as its storage.
- Converts a valid/ready write stream and a valid/ready read stream into arbitrated RAM read/write commands.
- Read data is prefetched into a 2-entry output buffer, so the consumer sees show-ahead data.
- Sits directly upstream of the RAM; the RAM ports below connect to the RAM model 1:1.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 8, RAM entries; power of two, ≥2. Total FIFO capacity is DEPTH+2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has data.
- in_ready  output  1  controller accepts in_data this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds the head entry.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  WIDTH  head of FIFO.
- ram_cs  output  1  RAM chip select.
- ram_wr  output  1  1 = write, 0 = read; meaningful only when ram_cs=1.
- ram_addr  output  $clog2(DEPTH)  RAM address.
- ram_wdata  output  WIDTH  RAM write data, equal to in_data.
- ram_rdata  input  WIDTH  RAM read data, valid the cycle after a read.
- fill_cnt  output  $clog2(DEPTH+2)+1  total entries held: RAM + in-flight + output buffer.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, ram_cnt, rd_inflight, obuf_cnt, fill_cnt = 0; prio_rd = 0.
  - out_valid=0, out_data=0, in_ready=0, ram_cs=0.
  - RAM contents are not cleared. Reset mid-operation discards all entries, including an in-flight read.
- Requests each cycle:
  - want_wr = in_valid && ram_cnt<DEPTH.
  - want_rd = ram_cnt>0 && (obuf_cnt + rd_inflight) < 2. Uses registered state only.
- Arbitration:
  - rd_grant = want_rd && (!want_wr || prio_rd).
  - wr_grant = want_wr && !rd_grant.
  - in_ready = (ram_cnt<DEPTH) && !rd_grant. in_ready may depend on in_valid; in_ready never depends on out_ready.
  - prio_rd toggles only on a conflict cycle (want_wr && want_rd): becomes 0 after a read win and 1 after a write win.
  - Under sustained load, neither side waits more than 1 cycle.
- RAM drive:
  - wr_grant: ram_cs=1, ram_wr=1, ram_addr=wr_ptr. At the edge, wr_ptr+1 (mod DEPTH) and ram_cnt+1.
  - rd_grant: ram_cs=1, ram_wr=0, ram_addr=rd_ptr. At the edge, rd_ptr+1 (mod DEPTH), ram_cnt-1, rd_inflight=1.
  - No grant: ram_cs=0, ram_wr=0, ram_addr holds its last value.
  - Never a read and a write in the same cycle.
- Capture: in a cycle with rd_inflight=1, ram_rdata is written into the output buffer tail at the edge; rd_inflight clears unless a new read is granted that cycle.
- Output buffer:
  - 2-entry FIFO; out_valid = obuf_cnt>0; out_data = head entry, registered.
  - A pop (out_valid && out_ready) and a capture in the same cycle are both honoured.
  - Capture into an empty buffer makes that word the head on the next cycle.
- Latency: word accepted in cycle 0 with everything idle → read in cycle 1 → ram_rdata in cycle 2 → out_valid=1 in cycle 3. There is no bypass path.
- fill_cnt = ram_cnt + rd_inflight + obuf_cnt, registered. It changes by +1 on accept, by -1 on pop, and is net 0 when both occur.
- Full: ram_cnt=DEPTH forces in_ready=0; the FIFO then holds DEPTH+2 entries once the buffer has filled. Empty: out_valid=0, and out_ready is ignored.
- Pointer wrap is modulo DEPTH. Ordering is strict FIFO across wrap.
- Throughput: with both sides continuously active, each side sustains ≥1 transfer per 2 cycles.

Test Plan:
- Reset with in_valid=1 → in_ready=0, ram_cs=0, out_valid=0, fill_cnt=0. Release rst_n, push 0xA5 in cycle 0 → ram_cs/ram_wr=1, ram_addr=0 in cycle 0; read ram_addr=0 in cycle 1; out_valid=1, out_data=0xA5 in cycle 3.
- Push 10 words 0x01..0x0A with out_ready=0, DEPTH=8 → all accepted and fill_cnt=10; the next push sees in_ready=0. Then pop all → 0x01..0x0A in order, out_valid=0, fill_cnt=0.
- Push and pop 20 words continuously (wrap twice) → data order preserved; ram_cs never asserted with both a read and a write in one cycle; in_ready low at most 1 consecutive cycle.
- Conflict cycle with prio_rd=0 → write wins and prio_rd becomes 1. Next conflict → read wins, in_ready=0 in that cycle.
- out_ready toggled randomly for 200 words → scoreboard match; fill_cnt always equals the model occupancy and never exceeds DEPTH+2.
- Assert rst_n low in a cycle with rd_inflight=1 and fill_cnt=5 → all outputs return to reset values immediately. After release, push 0x3C → first output is 0x3C.
